// File: rtl/jtcastle_snd_pkg.sv
// Shared constants for the sound-command latch: status-bit layout and
// default command queue depth.
package jtcastle_snd_pkg;

  // Default number of queued main-CPU commands.
  localparam int DEPTH_DEF = 4;

  // Bit positions in the status byte read by the sound CPU.
  localparam int STAT_NEMPTY = 0;
  localparam int STAT_FULL   = 1;
  localparam int STAT_OVF    = 2;

  // Build the status byte from the individual flags.
  function automatic logic [7:0] snd_status(
    input logic ovf,
    input logic full,
    input logic nempty
  );
    logic [7:0] st;
    st              = 8'h00;
    st[STAT_OVF]    = ovf;
    st[STAT_FULL]   = full;
    st[STAT_NEMPTY] = nempty;
    return st;
  endfunction

endpackage

// File: rtl/jtcastle_snd_fifo.sv
// Command byte queue: storage plus read/write pointers with an extra
// wrap bit so that full and empty can be told apart.
// A push while full is accepted only if a pop happens on the same edge;
// a pop while empty is ignored.
module jtcastle_snd_fifo
  import jtcastle_snd_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output logic [7:0] head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [7:0]  mem_r [DEPTH];
  logic [AW:0] wr_ptr_r;
  logic [AW:0] rd_ptr_r;
  logic        full_s;
  logic        empty_s;
  logic        push_ok_s;
  logic        pop_ok_s;

  // Flag decode and accept logic for this edge.
  always_comb begin
    empty_s   = (wr_ptr_r == rd_ptr_r);
    full_s    = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    pop_ok_s  = pop & ~empty_s;
    push_ok_s = push & (~full_s | pop_ok_s);
  end

  // Pointer update; both pointers return to zero on reset so the queue
  // is emptied immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
    end
  end

  // Storage write; contents are only meaningful between the pointers so
  // the array itself needs no reset.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= din;
    end
  end

  assign full  = full_s;
  assign empty = empty_s;
  assign head  = mem_r[rd_ptr_r[AW-1:0]];

endmodule

// File: rtl/jtcastle_snd_cmd.sv
// Main-CPU to sound-CPU command latch with a small queue.
// The main CPU strobes snd_irq with a byte; each strobe queues one byte.
// The sound CPU reads the queue head through latch_cs and the flags through
// stat_cs; every CPU access is counted once, however long it is stretched.
// int_n stays low while commands are waiting.
module jtcastle_snd_cmd
  import jtcastle_snd_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       snd_irq,
  input  logic [7:0] snd_latch,
  input  logic       cen,
  input  logic       latch_cs,
  input  logic       stat_cs,
  input  logic       rnw,
  output logic [7:0] dout,
  output logic       int_n,
  output logic       overflow
);

  logic       irq_r;
  logic       rd_prev_r;
  logic       st_prev_r;
  logic [7:0] hold_r;
  logic       ovf_r;
  logic       int_n_r;

  logic       push_s;
  logic       rd_cond_s;
  logic       st_cond_s;
  logic       rd_det_s;
  logic       st_det_s;
  logic       pop_ok_s;
  logic       ovf_set_s;
  logic       full_s;
  logic       empty_s;
  logic [7:0] head_s;
  logic [7:0] dout_s;

  jtcastle_snd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .din   (snd_latch),
    .pop   (rd_det_s),
    .full  (full_s),
    .empty (empty_s),
    .head  (head_s)
  );

  // Event decode: strobe rising edge, CPU access edges on cen cycles and
  // the overflow condition (a push while full without a matching pop).
  always_comb begin
    push_s    = snd_irq & ~irq_r;
    rd_cond_s = latch_cs & rnw;
    st_cond_s = stat_cs & rnw;
    rd_det_s  = cen & rd_cond_s & ~rd_prev_r;
    st_det_s  = cen & st_cond_s & ~st_prev_r;
    pop_ok_s  = rd_det_s & ~empty_s;
    ovf_set_s = push_s & full_s & ~rd_det_s;
  end

  // Strobe history, sampled every clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_r <= 1'b0;
    end else begin
      irq_r <= snd_irq;
    end
  end

  // Access history, sampled only on sound-CPU clock enables so a stretched
  // access looks like one access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_prev_r <= 1'b0;
      st_prev_r <= 1'b0;
    end else begin
      if (cen) begin
        rd_prev_r <= rd_cond_s;
        st_prev_r <= st_cond_s;
      end else begin
        rd_prev_r <= rd_prev_r;
        st_prev_r <= st_prev_r;
      end
    end
  end

  // Hold register keeps the last popped byte for reads of an empty queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_r <= 8'h00;
    end else begin
      if (pop_ok_s) begin
        hold_r <= head_s;
      end else begin
        hold_r <= hold_r;
      end
    end
  end

  // Sticky overflow; a new overflow wins over a same-edge status read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_r <= 1'b0;
    end else begin
      ovf_r <= ovf_set_s | (ovf_r & ~st_det_s);
    end
  end

  // Interrupt follows queue occupancy one clk late.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_n_r <= 1'b1;
    end else begin
      int_n_r <= empty_s;
    end
  end

  // Read data mux towards the sound CPU.
  always_comb begin
    dout_s = 8'hff;
    if (latch_cs) begin
      if (empty_s) begin
        dout_s = hold_r;
      end else begin
        dout_s = head_s;
      end
    end else if (stat_cs) begin
      dout_s = snd_status(ovf_r, full_s, ~empty_s);
    end else begin
      dout_s = 8'hff;
    end
  end

  assign dout     = dout_s;
  assign int_n    = int_n_r;
  assign overflow = ovf_r;

endmodule
